// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: line levels,
// FSM state encoding and the default word width.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with a zero flag; used to count the data bits of a frame.
module bit_down_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/serial_receiver.sv
// Serial frame receiver (start, DATA_W bits LSB-first, stop) with valid/ready delivery.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit before the stop bit and a parErr pulse.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              serIn,
  input  logic              ready,
  output logic [DATA_W-1:0] parOut,
  output logic              valid,
  output logic              frameErr,
  output logic              overrun,
`ifdef SERIAL_RX_PARITY_EN
  output logic              parErr,
`endif
  output logic              busy
);

  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_par_out;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_ld;
  logic              w_dec;
  logic              w_zero;
  logic              w_stop;
  logic              w_good;
  logic              w_frame_err;
`ifdef SERIAL_RX_PARITY_EN
  logic              r_par_bad;
  logic              r_par_err;
  logic              w_par_err;
`endif

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_ld     (w_ld),
    .i_ld_val (CNT_W'(DATA_W - 1)),
    .i_dec    (w_dec),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (serIn == START_BIT) w_state_next = DATA;
`ifdef SERIAL_RX_PARITY_EN
        DATA:    if (w_zero) w_state_next = PARITY;
`else
        DATA:    if (w_zero) w_state_next = STOP;
`endif
        PARITY:  w_state_next = STOP;
        STOP:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != IDLE);
    w_ld        = en && (r_state == IDLE) && (serIn == START_BIT);
    w_dec       = en && (r_state == DATA) && !w_zero;
    w_stop      = en && (r_state == STOP);
    w_frame_err = w_stop && (serIn != STOP_BIT);
`ifdef SERIAL_RX_PARITY_EN
    // A bad stop bit masks a parity error.
    w_par_err   = w_stop && (serIn == STOP_BIT) && r_par_bad;
    w_good      = w_stop && (serIn == STOP_BIT) && !r_par_bad;
`else
    w_good      = w_stop && (serIn == STOP_BIT);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_par_out   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      if (en && (r_state == DATA)) begin
        r_shift <= {serIn, r_shift[DATA_W-1:1]};
      end
`ifdef SERIAL_RX_PARITY_EN
      if (en && (r_state == PARITY)) begin
        r_par_bad <= ^{serIn, r_shift};
      end
      r_par_err <= w_par_err;
`endif
      r_frame_err <= w_frame_err;
      // A same-edge handshake frees the holding register for the new word.
      if (w_good && (!r_valid || ready)) begin
        r_par_out <= r_shift;
        r_valid   <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (r_valid && ready) begin
        r_overrun <= 1'b0;
      end else if (w_good && r_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign parOut   = r_par_out;
  assign valid    = r_valid;
  assign frameErr = r_frame_err;
  assign overrun  = r_overrun;
`ifdef SERIAL_RX_PARITY_EN
  assign parErr   = r_par_err;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed frames plus randomized traffic against a frame-level model.
module tb_serial_receiver;
  import serial_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
`ifdef SERIAL_RX_PARITY_EN
  localparam int STOP_POS = DW + 2;
`else
  localparam int STOP_POS = DW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          serIn;
  logic          ready;
  logic [DW-1:0] parOut;
  logic          valid;
  logic          frameErr;
  logic          overrun;
  logic          busy;
`ifdef SERIAL_RX_PARITY_EN
  logic          parErr;
`endif

  serial_receiver #(
    .DATA_W (DW),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .serIn    (serIn),
    .ready    (ready),
    .parOut   (parOut),
    .valid    (valid),
    .frameErr (frameErr),
    .overrun  (overrun),
`ifdef SERIAL_RX_PARITY_EN
    .parErr   (parErr),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame-level model: position within the frame plus the consumer-side holding word.
  int            m_pos;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_data;
  logic          m_pbit;
  logic          m_valid;
  logic          m_ovr;
  logic          m_ferr;
  logic          m_perr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pos   = 0;
    m_word  = '0;
    m_data  = '0;
    m_pbit  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("parOut", 32'(parOut), 32'(m_data));
    check_eq("overrun", 32'(overrun), 32'(m_ovr));
    check_eq("frameErr", 32'(frameErr), 32'(m_ferr));
    check_eq("busy", 32'(busy), 32'(m_pos != 0));
`ifdef SERIAL_RX_PARITY_EN
    check_eq("parErr", 32'(parErr), 32'(m_perr));
`endif
  endtask

  // One clock: drive the line, clock, advance the model, compare.
  task automatic step(input logic b, input logic rdy, input logic e);
    logic hs;
    logic good;
    logic loaded;
    serIn = b;
    ready = rdy;
    en    = e;
    @(posedge clk);
    #1;
    hs     = m_valid && rdy;
    good   = 1'b0;
    loaded = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    if (!e) begin
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (b == START_BIT) m_pos = 1;
    end else if (m_pos <= DW) begin
      m_word[m_pos-1] = b;
      m_pos++;
`ifdef SERIAL_RX_PARITY_EN
    end else if (m_pos == DW + 1) begin
      m_pbit = b;
      m_pos++;
`endif
    end else begin
      if (b != STOP_BIT) m_ferr = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
      else if ((^m_word) ^ m_pbit) m_perr = 1'b1;
`endif
      else good = 1'b1;
      m_pos = 0;
    end
    if (good) begin
      if (!m_valid || rdy) begin
        m_data  = m_word;
        m_valid = 1'b1;
        loaded  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    if (hs && !loaded) m_valid = 1'b0;
    if (hs) m_ovr = 1'b0;
    check_outputs();
  endtask

  task automatic pick(input logic rdy, input bit rnd, output logic r_o, output logic e_o);
    if (rnd) begin
      r_o = 1'($urandom_range(0, 1));
      e_o = ($urandom_range(0, 59) != 0);
    end else begin
      r_o = rdy;
      e_o = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_flip,
                            input logic rdy, input logic rdy_stop, input bit rnd);
    logic r;
    logic e;
    pick(rdy, rnd, r, e);
    step(START_BIT, r, e);
    for (int i = 0; i < DW; i++) begin
      pick(rdy, rnd, r, e);
      step(d[i], r, e);
    end
`ifdef SERIAL_RX_PARITY_EN
    pick(rdy, rnd, r, e);
    step((^d) ^ par_flip, r, e);
`endif
    pick(rdy_stop, rnd, r, e);
    step(stop_b, r, e);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(IDLE_LEVEL, rdy, 1'b1);
  endtask

  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2 rst = 1'b1;
  endtask

  logic [DW-1:0] rd;
  logic          rs;
  logic          rp;

  initial begin
    rst   = 1'b0;
    en    = 1'b0;
    serIn = IDLE_LEVEL;
    ready = 1'b0;
    model_reset();
    #12;
    check_outputs();
    rst = 1'b1;
    idle(2, 1'b1);

    // Single good frame, then framing error.
    send_frame(8'h0A, STOP_BIT, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_frame(8'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Overrun with back-to-back frames, then a one-cycle drain.
    send_frame(8'h0A, STOP_BIT, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, STOP_BIT, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Simultaneous accept of 0A and load of C3.
    send_frame(8'h0A, STOP_BIT, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, STOP_BIT, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);

    // Enable abort at data bit 4, then asynchronous reset mid-frame.
    step(START_BIT, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);
    send_frame(8'hFF, STOP_BIT, 1'b0, 1'b0, 1'b0, 1'b0);
    step(START_BIT, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    async_reset();
    idle(1, 1'b1);
    send_frame(8'hFF, STOP_BIT, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h0A, STOP_BIT, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    send_frame(8'h0A, STOP_BIT, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
`endif

    // Randomized traffic: random data, occasional bad stop/parity, random ready and enable.
    for (int f = 0; f < 150; f++) begin
      rd = DW'($urandom);
      rs = ($urandom_range(0, 9) != 0);
      rp = ($urandom_range(0, 7) == 0);
      send_frame(rd, rs, rp, 1'b0, 1'b0, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) step(IDLE_LEVEL, 1'($urandom_range(0, 1)), 1'b1);
      if (f == 75) async_reset();
    end
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Downstream stage of the serial transmitter: samples its serial output line and reassembles frames into parallel words.
- Frame on the line: idle high, one start bit (0), DATA_W data bits LSB-first, one stop bit (1). One bit per clk cycle, no oversampling.
- Delivers each good word to the consumer over a valid/ready handshake and flags framing errors and overruns.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..16).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  receiver enable; 0 forces IDLE and aborts any frame in progress.
- serIn  input  1  serial line; idle level 1.
- ready  input  1  consumer accepts parOut on a cycle where valid && ready.
- parOut  output  DATA_W  received word; stable while valid = 1.
- valid  output  1  parOut holds an unconsumed word.
- frameErr  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; a completed word was dropped because valid was still set.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE, shift register 0, counter 0, parOut 0, valid 0, frameErr 0, overrun 0, busy 0.
- IDLE: if en && serIn == 0, capture the start bit, load counter = DATA_W-1, go to DATA. Otherwise stay.
- DATA: each cycle, shift serIn into the MSB of the shift register (right shift, so the LSB-first stream lands in order). When counter == 0, go to STOP; otherwise decrement. Exactly DATA_W bits are taken.
- STOP, serIn == 1: frame good; see the delivery rules below. Return to IDLE.
- STOP, serIn == 0: pulse frameErr for one cycle, discard the word, return to IDLE. The 0 is not reused as a start bit.
- Delivery when valid == 0, or valid && ready in the same cycle: load parOut with the shift register and set valid. The simultaneous case counts as accepting the old word and loading the new one.
- Delivery when valid && !ready: keep the old word, drop the new one, set overrun.
- overrun clears on the cycle a handshake (valid && ready) completes.
- Latency: start bit sampled at edge 0, data bits at edges 1..DATA_W, stop bit at edge DATA_W+1. valid is high after that edge.
- Back-to-back frames: a start bit may appear on the cycle immediately after the stop bit. IDLE detects it with no dead cycle.
- valid clears on the edge where valid && ready, unless a new word loads on that same edge.
- en deasserted mid-frame: return to IDLE next edge and discard the partial word. valid, parOut and overrun are unaffected.
- Asynchronous reset mid-frame: everything returns to reset values, including a pending valid word.
- busy is combinational from state.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP, taking one even-parity bit (XOR of data bits plus parity bit == 0). Frame length becomes DATA_W+3.
  - On mismatch, the word is discarded and output parErr (1 bit) pulses for one cycle, coincident with the stop-bit sample.
  - frameErr still takes priority if the stop bit is also bad; in that case only frameErr pulses.
- Undefined: no PARITY state and no parErr port; frame is DATA_W+2 bits.

Decomposition:
- Package serial_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - constants START_BIT = 1'b0, STOP_BIT = 1'b1, IDLE_LEVEL = 1'b1;
  - the default DATA_W.
- The transmitter shares the same package.
- One sub-module, bit_down_counter: CNT_W-bit loadable down counter with ld/dec inputs and a zero flag.

Test Plan:
- Single frame: en = 1, ready = 1, drive 0 then bits of 8'h0A LSB-first (0,1,0,1,0,0,0,0) then 1 -> valid high after edge 9, parOut = 8'h0A, frameErr never pulses.
- Framing error: same frame, stop bit 0 -> frameErr pulses exactly one cycle after edge 9, valid stays 0, state returns to IDLE.
- Overrun: ready = 0, send 8'h0A then back-to-back 8'h55 -> parOut stays 8'h0A, overrun = 1. Raise ready for one cycle -> valid drops, overrun clears.
- Simultaneous accept and load: valid = 1 holding 8'h0A, ready = 1 on the edge 8'hC3 completes -> parOut = 8'hC3, valid stays 1, overrun stays 0.
- Abort: drop en at data bit 4, then drop rst mid-frame on a second frame -> both return to IDLE. A following 8'hFF frame is received correctly; after the reset, all outputs are 0.
- With SERIAL_RX_PARITY_EN: 8'h0A with parity 0 -> accepted. With parity 1 -> parErr pulses, valid stays 0.
